// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: runs a WIDTH-bit NOR/XOR/add LSB-first through
// an external 1-bit slice, one bit per clock, then pulses done.
module alu_serial_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_cin,
    output logic [1:0]       alu_op,
    input  logic             alu_s,
    input  logic             alu_cout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             carry_out_q, carry_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] bit_mask;
    logic             last_bit;
    logic             run;

    assign run      = (state_q == RUN);
    assign bit_mask = WIDTH'(1) << idx_q;
    assign last_bit = (idx_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                a_d     = a;
                b_d     = b;
                op_d    = op;
                idx_d   = '0;
                carry_d = (op == 2'b11);
            end
            RUN: begin
                result_d = (result_q & ~bit_mask) | (alu_s ? bit_mask : '0);
                carry_d  = alu_cout;
                idx_d    = idx_q + 1'b1;
                if (last_bit) begin
                    state_d     = DONE;
                    // logic ops never report a carry, whatever the slice says
                    carry_out_d = op_q[1] & alu_cout;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = run && last_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Slice drive is a pure function of flops, gated to zero outside RUN.
    assign alu_a     = run & |(a_q & bit_mask);
    assign alu_b     = run & |(b_q & bit_mask);
    assign alu_cin   = run & carry_q;
    assign alu_op    = run ? op_q : 2'b00;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl with a behavioural 1-bit slice.
module tb_alu_serial_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             busy, done, carry_out;
    logic [WIDTH-1:0] result;
    logic             alu_a, alu_b, alu_cin, alu_s, alu_cout;
    logic [1:0]       alu_op;

    int checks = 0;
    int errors = 0;

    always #50 clk = ~clk;

    alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
        .alu_s(alu_s), .alu_cout(alu_cout)
    );

    // 1-bit slice: 00 NOR, 01 XOR, 1x full add
    assign alu_s    = (alu_op == 2'b00) ? ~(alu_a | alu_b) :
                      (alu_op == 2'b01) ? (alu_a ^ alu_b) : (alu_a ^ alu_b ^ alu_cin);
    assign alu_cout = alu_op[1] & ((alu_a & alu_b) | (alu_a & alu_cin) | (alu_b & alu_cin));

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({31'd0, busy}, 32'd0, {tag, " busy"});
        chk({31'd0, done}, 32'd0, {tag, " done"});
        chk({24'd0, result}, 32'd0, {tag, " result"});
        chk({31'd0, carry_out}, 32'd0, {tag, " carry_out"});
        chk({27'd0, alu_a, alu_b, alu_cin, alu_op}, 32'd0, {tag, " alu_*"});
    endtask

    // Start one op; optionally pulse start with other operands at RUN cycle glitch.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb2, input logic [1:0] top,
                          input logic [7:0] er, input logic ec, input int glitch, input string tag);
        int busy_n, done_n, done_at;
        busy_n = 0; done_n = 0; done_at = -1;
        @(negedge clk);
        a = ta; b = tb2; op = top; start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin done_n++; if (done_at < 0) done_at = k; end
            if (k == 1) begin
                start = 1'b0;
                chk({30'd0, alu_op}, {30'd0, top}, {tag, " alu_op"});
                chk({31'd0, alu_cin}, {31'd0, (top == 2'b11)}, {tag, " alu_cin"});
            end
            if (k == 12)
                chk({27'd0, alu_a, alu_b, alu_cin, alu_op}, 32'd0, {tag, " idle alu_*"});
            if (glitch != 0 && k == glitch) begin
                start = 1'b1; a = ~ta; b = 8'h33; op = ~top;
            end
            if (glitch != 0 && k == glitch + 1) start = 1'b0;
        end
        chk({24'd0, result}, {24'd0, er}, {tag, " result"});
        chk({31'd0, carry_out}, {31'd0, ec}, {tag, " carry_out"});
        chk(done_n, 1, {tag, " done count"});
        chk(done_at, WIDTH + 1, {tag, " done cycle"});
        chk(busy_n, WIDTH + 1, {tag, " busy cycles"});
    endtask

    initial begin
        int seen;
        #10;
        chk_idle_outs("reset");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outs("post-reset idle");

        run_op(8'h5A, 8'h3C, 2'b10, 8'h96, 1'b0, 0, "add");
        run_op(8'hFF, 8'h01, 2'b10, 8'h00, 1'b1, 0, "add ovf");
        run_op(8'h10, 8'h0F, 2'b11, 8'h20, 1'b0, 0, "addc");
        run_op(8'h00, 8'h00, 2'b00, 8'hFF, 1'b0, 0, "nor0");
        run_op(8'hF0, 8'h0F, 2'b00, 8'h00, 1'b0, 0, "nor1");
        run_op(8'hA5, 8'hFF, 2'b01, 8'h5A, 1'b0, 0, "xor");
        run_op(8'h5A, 8'h3C, 2'b10, 8'h96, 1'b0, 3, "start ignored");

        // start raised during DONE waits until IDLE
        @(negedge clk);
        a = 8'h07; b = 8'h01; op = 2'b10; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (7) @(negedge clk);
        @(negedge clk);
        chk({31'd0, done}, 32'd1, "done-start done");
        a = 8'h01; b = 8'h02; op = 2'b10; start = 1'b1;
        @(negedge clk);
        chk({31'd0, busy}, 32'd0, "done-start idle gap");
        chk({24'd0, result}, 32'h08, "done-start held result");
        @(negedge clk);
        chk({31'd0, busy}, 32'd1, "done-start accepted");
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 12 && seen == 0; k++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk(seen, 1, "done-start finished");
        chk({24'd0, result}, 32'h03, "done-start result");

        // reset in the middle of RUN
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; op = 2'b10; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_idle_outs("mid-run reset");
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk(seen, 0, "mid-run reset no done");
        rst_n = 1'b1;
        run_op(8'h01, 8'h01, 2'b10, 8'h02, 1'b0, 0, "after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
